// File: rtl/cim_op_sequencer_if.sv
// Command/row-write handshake and array-drive bundle between a host and cim_op_sequencer.
// The host uses the master modport; the sequencer uses the slave modport.
interface cim_op_sequencer_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CMD_W  = 32
);
    localparam int unsigned NWL = 2 ** ADDR_W;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd;
    logic              ls_valid;
    logic              ls_ready;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_data;
    logic [NWL-1:0]    rwl1;
    logic [NWL-1:0]    rwl2;
    logic [NWL-1:0]    wwl;
    logic [DATA_W-1:0] wbl;
    logic [2:0]        op_mode;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] result_addr;

    modport master (
        output cmd_valid, cmd, ls_valid, ls_addr, ls_data,
        input  cmd_ready, ls_ready, rwl1, rwl2, wwl, wbl, op_mode, busy, done, err, result_addr
    );

    modport slave (
        input  cmd_valid, cmd, ls_valid, ls_addr, ls_data,
        output cmd_ready, ls_ready, rwl1, rwl2, wwl, wbl, op_mode, busy, done, err, result_addr
    );
endinterface

// File: rtl/cim_op_sequencer.sv
// Compute-in-memory op sequencer: turns compute commands and external row writes into
// registered one-hot wordline, bitline and mode drives for the array.
module cim_op_sequencer #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CMD_W   = 32,
    parameter int unsigned MAX_LEN = 5
) (
    input logic               clk,
    input logic               rst,
    cim_op_sequencer_if.slave bus
);
    localparam int unsigned NWL = 2 ** ADDR_W;
    localparam int unsigned KW  = MAX_LEN + 1;

    typedef enum logic [1:0] {StIdle, StExec, StMulIter, StLsWr} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rs1_q, rs1_d, ping_q, ping_d, pong_q, pong_d, res_q, res_d;
    logic [2:0]        op_q, op_d, op_mode_q, op_mode_d;
    logic [KW-1:0]     k_q, k_d, last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d, wbl_q, wbl_d;
    logic [NWL-1:0]    rwl1_q, rwl1_d, rwl2_q, rwl2_d, wwl_q, wwl_d;
    logic              done_q, done_d, err_q, err_d;

    logic [ADDR_W-1:0] cmd_rd, cmd_rs2, cmd_rs1;
    logic [2:0]        cmd_len, cmd_op;
    logic              cmd_acc, ls_acc, unused_cmd;

    assign cmd_rd     = bus.cmd[ADDR_W-1:0];
    assign cmd_rs2    = bus.cmd[2*ADDR_W-1:ADDR_W];
    assign cmd_rs1    = bus.cmd[3*ADDR_W-1:2*ADDR_W];
    assign cmd_len    = bus.cmd[3*ADDR_W+2:3*ADDR_W];
    assign cmd_op     = bus.cmd[3*ADDR_W+5:3*ADDR_W+3];
    assign unused_cmd = ^bus.cmd;

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.ls_ready  = (state_q == StIdle) & ~bus.cmd_valid;
    assign cmd_acc       = bus.cmd_valid & bus.cmd_ready;
    assign ls_acc        = bus.ls_valid & bus.ls_ready;

    function automatic logic [NWL-1:0] onehot(input logic [ADDR_W-1:0] a);
        return NWL'(1) << a;
    endfunction

    // Next-state: ping/pong reuse the rs2/rd slots for EXEC and the row address for LS_WR.
    always_comb begin
        state_d = state_q;
        rs1_d   = rs1_q;
        ping_d  = ping_q;
        pong_d  = pong_q;
        op_d    = op_q;
        k_d     = k_q;
        last_d  = last_q;
        data_d  = data_q;
        err_d   = 1'b0;
        if (rst) begin
            state_d = StIdle;
            rs1_d   = '0;
            ping_d  = '0;
            pong_d  = '0;
            op_d    = '0;
            k_d     = '0;
            last_d  = '0;
            data_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_acc) begin
                        if (cmd_op == 3'd7 && 32'(cmd_len) > MAX_LEN) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = (cmd_op == 3'd7) ? StMulIter : StExec;
                            rs1_d   = cmd_rs1;
                            ping_d  = cmd_rs2;
                            pong_d  = cmd_rd;
                            op_d    = cmd_op;
                            k_d     = '0;
                            last_d  = (KW'(1) << cmd_len) - KW'(1);
                        end
                    end else if (ls_acc) begin
                        state_d = StLsWr;
                        pong_d  = bus.ls_addr;
                        data_d  = bus.ls_data;
                        op_d    = 3'd0;
                    end
                end
                StExec, StLsWr: state_d = StIdle;
                StMulIter: begin
                    ping_d = pong_q;
                    pong_d = ping_q;
                    if (k_q == last_q) begin
                        state_d = StIdle;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are decoded from next state so they appear registered in the active cycle.
    always_comb begin
        rwl1_d    = '0;
        rwl2_d    = '0;
        wwl_d     = '0;
        wbl_d     = '0;
        op_mode_d = 3'd0;
        done_d    = 1'b0;
        res_d     = rst ? '0 : res_q;
        unique case (state_d)
            StExec: begin
                rwl1_d    = onehot(rs1_d);
                rwl2_d    = (op_d != 3'd0 && op_d != 3'd4) ? onehot(ping_d) : '0;
                wwl_d     = onehot(pong_d);
                op_mode_d = op_d;
                done_d    = 1'b1;
            end
            StMulIter: begin
                rwl1_d    = onehot(rs1_d + ADDR_W'(k_d));
                rwl2_d    = onehot(ping_d);
                wwl_d     = onehot(pong_d);
                op_mode_d = 3'd7;
                if (k_d == last_d) begin
                    done_d = 1'b1;
                    res_d  = pong_d;
                end
            end
            StLsWr: begin
                wwl_d  = onehot(pong_d);
                wbl_d  = data_d;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        rs1_q     <= rs1_d;
        ping_q    <= ping_d;
        pong_q    <= pong_d;
        op_q      <= op_d;
        k_q       <= k_d;
        last_q    <= last_d;
        data_q    <= data_d;
        res_q     <= res_d;
        rwl1_q    <= rwl1_d;
        rwl2_q    <= rwl2_d;
        wwl_q     <= wwl_d;
        wbl_q     <= wbl_d;
        op_mode_q <= op_mode_d;
        done_q    <= done_d;
        err_q     <= err_d;
    end

    assign bus.rwl1        = rwl1_q;
    assign bus.rwl2        = rwl2_q;
    assign bus.wwl         = wwl_q;
    assign bus.wbl         = wbl_q;
    assign bus.op_mode     = op_mode_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.result_addr = res_q;
endmodule
